mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Owns the single-port 256x8 unified memory (instruction + data) of the pipelined 8-bit CPU and shares it between three requesters: IF-stage fetch, MEM-stage data access and a debug program loader. On reset it sequences boot. It reads the reset vector at M[RESET_VEC_ADDR], hands that vector to the PC and holds the core until then. Pipeline stall for fetch is derived from its grant.

Parameters:
AW, 8, address width
DW, 8, data width
RESET_VEC_ADDR, 8'h00, address holding the boot/reset vector
CNT_W, 16, width of the saturating fetch-stall counter

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock, asynchronous assert, active-low
if_req  in  1  fetch request (read only)
if_addr  in  AW  fetch address (PC)
if_gnt  out  1  fetch granted this cycle; ~if_gnt with if_req = IF stall
if_rvalid  out  1  fetch data valid on rdata
dm_req  in  1  MEM-stage request
dm_we  in  1  1 = write
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_gnt  out  1  data request granted
dm_rvalid  out  1  data read valid on rdata
ld_en  in  1  loader mode request; holds core
ld_req  in  1  loader access request
ld_we  in  1  loader write
ld_addr  in  AW  loader address
ld_wdata  in  DW  loader write data
ld_gnt  out  1  loader granted
ld_rvalid  out  1  loader read valid on rdata
rdata  out  DW  broadcast read data (= mem_rdata)
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid 1 cycle after mem_en & ~mem_we
cpu_hold  out  1  freezes PC/pipeline
pc_init_valid  out  1  one-cycle pulse: load PC with pc_init
pc_init  out  AW  boot vector
stall_cnt  out  CNT_W  saturating count of cycles with if_req & ~if_gnt in RUN

Behaviour:
- Reset (async, rstn=0): state=BOOT_RD; all gnt/rvalid/mem_en/mem_we/pc_init_valid=0; pc_init=0; stall_cnt=0; cpu_hold=1; read-owner tag cleared (no pending read).
- FSM states:
  - BOOT_RD: mem_en=1, mem_we=0, mem_addr=RESET_VEC_ADDR. Goes to LOAD if ld_en, else BOOT_WT.
  - BOOT_WT: pc_init<=mem_rdata; pc_init_valid=1 for this cycle. Goes to RUN (LOAD if ld_en).
  - RUN: fixed priority dm > if; ld ignored. Goes to LOAD when ld_en=1.
  - LOAD: only ld served; if_gnt=dm_gnt=0. Goes to BOOT_RD when ld_en=0, which re-boots the core.
- cpu_hold=1 in BOOT_RD, BOOT_WT and LOAD; 0 in RUN.
- Grants are combinational in the request cycle. mem_* is driven from the granted requester in the same cycle. Ungranted requests are not queued; the requester must hold req until gnt.
- Read return: registered 2-bit owner tag. rvalid pulses on exactly the owner's line the cycle after a granted read. Writes produce no rvalid. A read granted in the last RUN cycle still returns its rvalid in the first LOAD cycle.
- dm and if never both granted. At most one mem access per cycle.
- stall_cnt increments only in RUN when if_req & ~if_gnt. It saturates at all-ones and never wraps.
- Reset mid-access: pending rvalid is dropped; boot restarts from BOOT_RD.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - FSM state encoding: BOOT_RD, BOOT_WT, RUN, LOAD
  - requester-id constants: NONE, IF, DM, LD
  - AW/DW defaults and RESET_VEC_ADDR
- One natural sub-module: sat_counter (parameter CNT_W; inc, clear inputs) for stall_cnt. The rest is a single FSM + grant mux.

Test Plan:
- Boot: M[0]=0x10, release rstn. Cycle 1 mem_addr=0x00 read. Cycle 2 pc_init_valid=1 with pc_init=0x10. Cycle 3 cpu_hold=0.
- Conflict: RUN, if_req addr 0x05 + dm_req read 0x20 (M[0x20]=0x3C) -> dm_gnt=1, if_gnt=0, mem_addr=0x20. Next cycle dm_rvalid=1 with rdata=0x3C and if_gnt=1, mem_addr=0x05. stall_cnt=1.
- Data write: dm write 0x30<-0xAA concurrent with if_req -> mem_we=1, mem_wdata=0xAA, no rvalid. Read-back of 0x30 returns 0xAA.
- Loader: ld_en=1 in RUN -> next cycle cpu_hold=1, if_gnt=0. Loader writes M[0]=0x40, M[0x40]=0x7C. Drop ld_en -> BOOT_RD then pc_init_valid with pc_init=0x40.
- Mid-read reset: rstn low the cycle after a granted fetch read -> if_rvalid never asserts, cpu_hold=1 immediately, boot repeats after release.
- Saturation: CNT_W=4, 20 consecutive RUN cycles of dm+if conflict -> stall_cnt=15 and stays 15.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared constants for the unified-memory port arbiter: default widths,
// boot vector location, FSM state encoding and requester ids.
package cpu_mem_pkg;

  localparam int          AW_DEF         = 8;
  localparam int          DW_DEF         = 8;
  localparam logic [7:0]  RESET_VEC_DEF  = 8'h00;

  localparam logic [1:0]  ST_BOOT_RD = 2'd0;
  localparam logic [1:0]  ST_BOOT_WT = 2'd1;
  localparam logic [1:0]  ST_RUN     = 2'd2;
  localparam logic [1:0]  ST_LOAD    = 2'd3;

  // Identifies which requester owns the read data returning next cycle.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_LD   = 2'd3
  } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter: boots the core from the reset vector,
// then shares the port between data (priority), fetch and the debug loader.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int             AW             = AW_DEF,
  parameter int             DW             = DW_DEF,
  parameter logic [AW-1:0]  RESET_VEC_ADDR = AW'(RESET_VEC_DEF),
  parameter int             CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [AW-1:0]    dm_addr,
  input  logic [DW-1:0]    dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  input  logic             ld_en,
  input  logic             ld_req,
  input  logic             ld_we,
  input  logic [AW-1:0]    ld_addr,
  input  logic [DW-1:0]    ld_wdata,
  output logic             ld_gnt,
  output logic             ld_rvalid,
  output logic [DW-1:0]    rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             cpu_hold,
  output logic             pc_init_valid,
  output logic [AW-1:0]    pc_init,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0]    state_q, state_d;
  req_id_e       owner_q, owner_d;
  logic [AW-1:0] pc_init_q, pc_init_d;
  logic          stall_inc;

  // Everything combinational is gated by rstn so the port is quiet while
  // reset is asserted, even though the state register already reads BOOT_RD.
  always_comb begin
    state_d       = state_q;
    owner_d       = REQ_NONE;
    pc_init_d     = pc_init_q;
    pc_init       = pc_init_q;
    pc_init_valid = 1'b0;
    if_gnt        = 1'b0;
    dm_gnt        = 1'b0;
    ld_gnt        = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (rstn) begin
      case (state_q)
        ST_BOOT_RD: begin
          mem_en   = 1'b1;
          mem_addr = RESET_VEC_ADDR;
          state_d  = ld_en ? ST_LOAD : ST_BOOT_WT;
        end
        ST_BOOT_WT: begin
          // Vector is presented in the same cycle as the valid pulse.
          pc_init_d     = AW'(mem_rdata);
          pc_init       = AW'(mem_rdata);
          pc_init_valid = 1'b1;
          state_d       = ld_en ? ST_LOAD : ST_RUN;
        end
        ST_RUN: begin
          if (dm_req) begin
            dm_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            owner_d   = dm_we ? REQ_NONE : REQ_DM;
          end else if (if_req) begin
            if_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            owner_d   = REQ_IF;
          end
          state_d = ld_en ? ST_LOAD : ST_RUN;
        end
        default: begin
          if (ld_req) begin
            ld_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            owner_d   = ld_we ? REQ_NONE : REQ_LD;
          end
          // Leaving loader mode re-boots so a freshly loaded vector is used.
          state_d = ld_en ? ST_LOAD : ST_BOOT_RD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_BOOT_RD;
      owner_q   <= REQ_NONE;
      pc_init_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      pc_init_q <= pc_init_d;
    end
  end

  assign if_rvalid = (owner_q == REQ_IF);
  assign dm_rvalid = (owner_q == REQ_DM);
  assign ld_rvalid = (owner_q == REQ_LD);
  assign rdata     = mem_rdata;
  assign cpu_hold  = (state_q != ST_RUN);
  assign stall_inc = (state_q == ST_RUN) && if_req && !if_gnt;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter against a cycle-level
// behavioural model with its own shadow memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req, dm_req, dm_we, ld_en, ld_req, ld_we;
  logic [7:0]  if_addr, dm_addr, dm_wdata, ld_addr, ld_wdata;
  logic [7:0]  mem_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, ld_rvalid;
  logic [7:0]  rdata, mem_addr, mem_wdata, pc_init;
  logic        mem_en, mem_we, cpu_hold, pc_init_valid;
  logic [15:0] stall_cnt;

  logic        s_if_gnt, s_if_rvalid, s_dm_gnt, s_dm_rvalid, s_ld_gnt, s_ld_rvalid;
  logic [7:0]  s_rdata, s_mem_addr, s_mem_wdata, s_pc_init;
  logic        s_mem_en, s_mem_we, s_cpu_hold, s_pc_init_valid;
  logic [3:0]  s_stall_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter u_dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .ld_en(ld_en), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_hold(cpu_hold),
    .pc_init_valid(pc_init_valid), .pc_init(pc_init), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation checks.
  mem_port_arbiter #(.CNT_W(4)) u_sat (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(s_if_gnt), .if_rvalid(s_if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(s_dm_gnt), .dm_rvalid(s_dm_rvalid),
    .ld_en(ld_en), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(s_ld_gnt), .ld_rvalid(s_ld_rvalid),
    .rdata(s_rdata), .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .cpu_hold(s_cpu_hold),
    .pc_init_valid(s_pc_init_valid), .pc_init(s_pc_init), .stall_cnt(s_stall_cnt)
  );

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int n_cmp  = 0;
  int n_err  = 0;
  int cycle  = 0;
  bit verbose = 1'b0;

  // Model: 0 boot read, 1 boot vector, 2 running, 3 loader mode.
  int         m_mode;
  int         m_pend;          // 0 none, 1 fetch, 2 data, 3 loader
  logic [7:0] m_pend_data;
  logic [7:0] m_boot_data;
  logic [7:0] m_pc;
  longint     m_stalls;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  task automatic idle();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
  endtask

  task automatic rand_core();
    if_req   = ($urandom_range(0, 3) != 0);
    if_addr  = 8'($urandom);
    dm_req   = ($urandom_range(0, 2) == 0);
    dm_we    = $urandom_range(0, 1) == 1;
    dm_addr  = 8'($urandom);
    dm_wdata = 8'($urandom);
    ld_req   = $urandom_range(0, 1) == 1;
    ld_we    = $urandom_range(0, 1) == 1;
    ld_addr  = 8'($urandom);
    ld_wdata = 8'($urandom);
  endtask

  // One clock: check outputs mid-cycle, then advance memory and model.
  task automatic step();
    logic       e_if, e_dm, e_ld, e_en, e_we;
    logic [7:0] e_addr, e_wd;
    logic       c_en, c_we;
    logic [7:0] c_addr, c_wd;
    longint     sat16, sat4;
    #1;
    if (!rstn) begin
      m_mode = 0; m_pend = 0; m_stalls = 0; m_pc = 8'h00;
    end
    e_if = 0; e_dm = 0; e_ld = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
    if (rstn) begin
      if (m_mode == 0) begin
        e_en = 1; e_addr = 8'h00;
      end else if (m_mode == 2) begin
        if (dm_req) begin
          e_dm = 1; e_en = 1; e_we = dm_we; e_addr = dm_addr; e_wd = dm_wdata;
        end else if (if_req) begin
          e_if = 1; e_en = 1; e_addr = if_addr;
        end
      end else if (m_mode == 3 && ld_req) begin
        e_ld = 1; e_en = 1; e_we = ld_we; e_addr = ld_addr; e_wd = ld_wdata;
      end
    end
    check_val("if_gnt", 32'(if_gnt), 32'(e_if));
    check_val("dm_gnt", 32'(dm_gnt), 32'(e_dm));
    check_val("ld_gnt", 32'(ld_gnt), 32'(e_ld));
    check_val("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) begin
      check_val("mem_we", 32'(mem_we), 32'(e_we));
      check_val("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) check_val("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    end
    check_val("cpu_hold", 32'(cpu_hold), 32'(!(rstn && m_mode == 2)));
    check_val("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
    check_val("dm_rvalid", 32'(dm_rvalid), 32'(m_pend == 2));
    check_val("ld_rvalid", 32'(ld_rvalid), 32'(m_pend == 3));
    if (m_pend != 0) check_val("rdata", 32'(rdata), 32'(m_pend_data));
    check_val("pc_init_valid", 32'(pc_init_valid), 32'(rstn && m_mode == 1));
    check_val("pc_init", 32'(pc_init), 32'((rstn && m_mode == 1) ? m_boot_data : m_pc));
    sat16 = (m_stalls > 65535) ? 65535 : m_stalls;
    sat4  = (m_stalls > 15) ? 15 : m_stalls;
    check_val("stall_cnt", 32'(stall_cnt), 32'(sat16));
    check_val("stall_cnt_w4", 32'(s_stall_cnt), 32'(sat4));
    if (verbose && mem_en)
      $display("cycle %0d: %s addr=%02h wdata=%02h gnt(if,dm,ld)=%0b%0b%0b hold=%0b stall=%0d",
               cycle, mem_we ? "WR" : "RD", mem_addr, mem_wdata, if_gnt, dm_gnt, ld_gnt,
               cpu_hold, stall_cnt);
    c_en = mem_en; c_we = mem_we; c_addr = mem_addr; c_wd = mem_wdata;

    @(posedge clk);
    cycle++;
    if (c_en) begin
      if (c_we) mem[c_addr] = c_wd;
      else      mem_rdata <= mem[c_addr];
    end
    if (rstn) begin
      m_pend = 0;
      case (m_mode)
        0: begin m_boot_data = ref_mem[8'h00]; m_mode = ld_en ? 3 : 1; end
        1: begin m_pc = m_boot_data; m_mode = ld_en ? 3 : 2; end
        2: begin
          if (dm_req && if_req) m_stalls++;
          m_mode = ld_en ? 3 : 2;
        end
        default: m_mode = ld_en ? 3 : 0;
      endcase
      if (e_en && e_we) ref_mem[e_addr] = e_wd;
      else if (e_en && (e_if || e_dm || e_ld)) begin
        m_pend      = e_if ? 1 : (e_dm ? 2 : 3);
        m_pend_data = ref_mem[e_addr];
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h10;
    mem[8'h20] = 8'h3C;
    ref_mem   = mem;
    mem_rdata = 8'h00;
    m_boot_data = 8'h00;
    m_pend_data = 8'h00;
    idle();
    ld_en = 0;
    rstn  = 0;
    @(negedge clk);
    verbose = 1;

    // Reset, then boot from M[0].
    step(); step();
    rstn = 1;
    for (int i = 0; i < 3; i++) step();

    // Fetch/data conflict: data wins, fetch follows.
    if_req = 1; if_addr = 8'h05; dm_req = 1; dm_we = 0; dm_addr = 8'h20;
    step();
    dm_req = 0;
    step();
    idle(); step();

    // Data write alongside a fetch, then read it back.
    if_req = 1; if_addr = 8'h06; dm_req = 1; dm_we = 1; dm_addr = 8'h30; dm_wdata = 8'hAA;
    step();
    if_req = 0; dm_we = 0;
    step();
    idle(); step();
    verbose = 0;

    // Random running traffic.
    for (int i = 0; i < 300; i++) begin rand_core(); step(); end

    // Loader session: random accesses, then plant a new vector.
    ld_en = 1;
    for (int i = 0; i < 60; i++) begin rand_core(); step(); end
    verbose = 1;
    idle(); ld_req = 1; ld_we = 1; ld_addr = 8'h00; ld_wdata = 8'h40; step();
    ld_addr = 8'h40; ld_wdata = 8'h7C; step();
    ld_we = 0; ld_addr = 8'h40; step();
    idle(); ld_en = 0;
    for (int i = 0; i < 4; i++) step();

    // Reset the cycle after a granted fetch.
    if_req = 1; if_addr = 8'h12; step();
    rstn = 0; idle(); step(); step();
    rstn = 1;
    for (int i = 0; i < 4; i++) step();

    // Sustained conflict to drive the narrow counter into saturation.
    if_req = 1; dm_req = 1; dm_we = 0;
    for (int i = 0; i < 22; i++) begin
      if_addr = 8'($urandom); dm_addr = 8'($urandom); step();
    end
    idle(); step();
    verbose = 0;

    // Mixed traffic with occasional loader sessions and resets.
    for (int i = 0; i < 3000; i++) begin
      rand_core();
      if ($urandom_range(0, 40) == 0) ld_en = ~ld_en;
      rstn = ($urandom_range(0, 150) != 0);
      step();
    end
    rstn = 1; ld_en = 0; idle();
    for (int i = 0; i < 4; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
